drink_vending_fsm: RTL and testbench

//  Vending-machine controller. Accumulates inserted coin values into a running credit.

---
 rtl/vend_pkg.sv | 23 ++
 rtl/drink_vending_fsm_if.sv | 32 +++
 rtl/vend_price_lookup.sv | 28 ++
 rtl/drink_vending_fsm.sv | 93 +++++++++
 tb/tb_drink_vending_fsm.sv | 140 ++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared drink codes, default prices and FSM state encoding
// for the drink vending controller.
package vend_pkg;

    localparam logic [2:0] DRINK_NONE   = 3'b000;
    localparam logic [2:0] DRINK_TEA    = 3'b001;
    localparam logic [2:0] DRINK_COKE   = 3'b010;
    localparam logic [2:0] DRINK_COFFEE = 3'b011;
    localparam logic [2:0] DRINK_MILK   = 3'b100;

    localparam logic [31:0] DEF_PRICE_TEA    = 32'd10;
    localparam logic [31:0] DEF_PRICE_COKE   = 32'd15;
    localparam logic [31:0] DEF_PRICE_COFFEE = 32'd20;
    localparam logic [31:0] DEF_PRICE_MILK   = 32'd25;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_VEND,
        ST_REFUND
    } state_t;

endpackage

// File: rtl/drink_vending_fsm_if.sv
// Panel/dispenser bundle: master = coin/selector panel, slave = controller.
// Ports: coin, drink_choose, cancel (to slave); change, total_coin, avail (from slave; avail only with VEND_AVAIL_EN).
interface drink_vending_fsm_if;

    logic [31:0] coin;
    logic [2:0]  drink_choose;
    logic        cancel;
    logic [31:0] change;
    logic [31:0] total_coin;
`ifdef VEND_AVAIL_EN
    logic [3:0]  avail;

    modport master (
        output coin, drink_choose, cancel,
        input  change, total_coin, avail
    );
    modport slave (
        input  coin, drink_choose, cancel,
        output change, total_coin, avail
    );
`else
    modport master (
        output coin, drink_choose, cancel,
        input  change, total_coin
    );
    modport slave (
        input  coin, drink_choose, cancel,
        output change, total_coin
    );
`endif

endinterface

// File: rtl/vend_price_lookup.sv
// Combinational drink code -> {valid, price} lookup.
// Ports: code in [2:0]; valid out; price out [31:0] (0 when invalid).
module vend_price_lookup
    import vend_pkg::*;
#(
    parameter logic [31:0] PRICE_TEA    = DEF_PRICE_TEA,
    parameter logic [31:0] PRICE_COKE   = DEF_PRICE_COKE,
    parameter logic [31:0] PRICE_COFFEE = DEF_PRICE_COFFEE,
    parameter logic [31:0] PRICE_MILK   = DEF_PRICE_MILK
) (
    input  logic [2:0]  code,
    output logic        valid,
    output logic [31:0] price
);

    always_comb begin
        valid = 1'b0;
        price = '0;
        unique case (code)
            DRINK_TEA:    begin valid = 1'b1; price = PRICE_TEA;    end
            DRINK_COKE:   begin valid = 1'b1; price = PRICE_COKE;   end
            DRINK_COFFEE: begin valid = 1'b1; price = PRICE_COFFEE; end
            DRINK_MILK:   begin valid = 1'b1; price = PRICE_MILK;   end
            default:      begin valid = 1'b0; price = '0;           end
        endcase
    end

endmodule

// File: rtl/drink_vending_fsm.sv
// Vending controller: accumulates credit, vends on affordable selection, refunds on cancel.
// Ports: clk, reset (async active-low), bus (slave). Optional avail output with VEND_AVAIL_EN.
module drink_vending_fsm
    import vend_pkg::*;
#(
    parameter logic [31:0] PRICE_TEA    = DEF_PRICE_TEA,
    parameter logic [31:0] PRICE_COKE   = DEF_PRICE_COKE,
    parameter logic [31:0] PRICE_COFFEE = DEF_PRICE_COFFEE,
    parameter logic [31:0] PRICE_MILK   = DEF_PRICE_MILK
) (
    input  logic               clk,
    input  logic               reset,
    drink_vending_fsm_if.slave bus
);

    state_t      state_q, state_d;
    logic [31:0] total_q, total_d;
    logic [31:0] change_q, change_d;
    logic [32:0] sum;
    logic [31:0] credit, eff, reject;
    logic        sel_valid;
    logic [31:0] sel_price;

    vend_price_lookup #(
        .PRICE_TEA    (PRICE_TEA),
        .PRICE_COKE   (PRICE_COKE),
        .PRICE_COFFEE (PRICE_COFFEE),
        .PRICE_MILK   (PRICE_MILK)
    ) u_lookup (
        .code  (bus.drink_choose),
        .valid (sel_valid),
        .price (sel_price)
    );

    always_comb begin
        // Only CREDIT holds a nonzero balance; the others start from zero.
        credit = (state_q == ST_CREDIT) ? total_q : '0;
        sum    = {1'b0, credit} + {1'b0, bus.coin};
        eff    = sum[31:0];
        reject = '0;
        // A coin that would wrap the credit bounces straight back out.
        if (sum[32]) begin
            eff    = credit;
            reject = bus.coin;
        end
        state_d  = (eff != '0) ? ST_CREDIT : ST_IDLE;
        total_d  = eff;
        change_d = reject;
        if (bus.cancel) begin
            state_d  = ST_REFUND;
            total_d  = '0;
            change_d = eff + reject;
        end else if (sel_valid && (eff >= sel_price)) begin
            state_d  = ST_VEND;
            total_d  = '0;
            change_d = (eff - sel_price) + reject;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            total_q  <= '0;
            change_q <= '0;
        end else begin
            state_q  <= state_d;
            total_q  <= total_d;
            change_q <= change_d;
        end
    end

    assign bus.total_coin = total_q;
    assign bus.change     = change_q;

`ifdef VEND_AVAIL_EN
    logic [3:0] avail_q, avail_d;

    always_comb begin
        avail_d[0] = (total_d >= PRICE_TEA);
        avail_d[1] = (total_d >= PRICE_COKE);
        avail_d[2] = (total_d >= PRICE_COFFEE);
        avail_d[3] = (total_d >= PRICE_MILK);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) avail_q <= '0;
        else        avail_q <= avail_d;
    end

    assign bus.avail = avail_q;
`endif

endmodule

// File: tb/tb_drink_vending_fsm.sv
// Directed scoreboard bench for drink_vending_fsm.
// Expected {change,total} pushed when driven, popped one edge later.
module tb_drink_vending_fsm;

    typedef struct {
        logic [31:0] chg;
        logic [31:0] tot;
    } exp_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    exp_t sb[$];

    drink_vending_fsm_if bus ();

    drink_vending_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [31:0] c, input logic [2:0] d,
                        input logic k, input logic [31:0] ec,
                        input logic [31:0] et);
        exp_t e;
        @(negedge clk);
        bus.coin         = c;
        bus.drink_choose = d;
        bus.cancel       = k;
        e.chg = ec;
        e.tot = et;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk("change", bus.change, e.chg);
        chk("total_coin", bus.total_coin, e.tot);
`ifdef VEND_AVAIL_EN
        begin
            logic [3:0] ea;
            ea[0] = (e.tot >= 32'd10);
            ea[1] = (e.tot >= 32'd15);
            ea[2] = (e.tot >= 32'd20);
            ea[3] = (e.tot >= 32'd25);
            chk("avail", {28'd0, bus.avail}, {28'd0, ea});
        end
`endif
    endtask

    initial begin
        errors           = 0;
        checks           = 0;
        reset            = 1'b0;
        bus.coin         = '0;
        bus.drink_choose = 3'b000;
        bus.cancel       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_change", bus.change, 32'd0);
        chk("reset_total", bus.total_coin, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // accumulate then coffee
        step(32'd10, 3'b000, 1'b0, 32'd0, 32'd10);
        step(32'd5,  3'b000, 1'b0, 32'd0, 32'd15);
        step(32'd1,  3'b000, 1'b0, 32'd0, 32'd16);
        step(32'd10, 3'b000, 1'b0, 32'd0, 32'd26);
        step(32'd0,  3'b011, 1'b0, 32'd6, 32'd0);
        step(32'd0,  3'b000, 1'b0, 32'd0, 32'd0);

        // cancel, then held cancel
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd10);
        step(32'd5,  3'b000, 1'b0, 32'd0,  32'd15);
        step(32'd1,  3'b000, 1'b0, 32'd0,  32'd16);
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd26);
        step(32'd0,  3'b000, 1'b1, 32'd26, 32'd0);
        step(32'd0,  3'b000, 1'b1, 32'd0,  32'd0);
        step(32'd0,  3'b000, 1'b0, 32'd0,  32'd0);

        // zero-coin gap, then tea
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd10);
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd20);
        step(32'd0,  3'b000, 1'b0, 32'd0,  32'd20);
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd30);
        step(32'd0,  3'b001, 1'b0, 32'd20, 32'd0);

        // unaffordable and invalid selections
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd10);
        step(32'd5,  3'b000, 1'b0, 32'd0,  32'd15);
        step(32'd1,  3'b000, 1'b0, 32'd0,  32'd16);
        step(32'd0,  3'b100, 1'b0, 32'd0,  32'd16);
        step(32'd0,  3'b111, 1'b0, 32'd0,  32'd16);
        step(32'd0,  3'b100, 1'b1, 32'd16, 32'd0);

        // held selection with zero credit
        step(32'd0,  3'b001, 1'b0, 32'd0,  32'd0);

        // same-cycle coin completes exact price
        step(32'd10, 3'b000, 1'b0, 32'd0,  32'd10);
        step(32'd5,  3'b010, 1'b0, 32'd0,  32'd0);
        step(32'd0,  3'b000, 1'b0, 32'd0,  32'd0);

        // overflowing coin rejected into change
        step(32'hFFFF_FFF0, 3'b000, 1'b0, 32'd0,  32'hFFFF_FFF0);
        step(32'h20,        3'b000, 1'b0, 32'h20, 32'hFFFF_FFF0);
        step(32'd0,         3'b000, 1'b0, 32'd0,  32'hFFFF_FFF0);
        step(32'd0, 3'b000, 1'b1, 32'hFFFF_FFF0, 32'd0);

        // asynchronous reset mid-credit
        step(32'd10, 3'b000, 1'b0, 32'd0, 32'd10);
        @(negedge clk);
        bus.coin = '0;
        #2 reset = 1'b0;
        #1;
        chk("async_total", bus.total_coin, 32'd0);
        chk("async_change", bus.change, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step(32'd5, 3'b000, 1'b0, 32'd0, 32'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
